// File: rtl/cache_pkg.sv
// Shared types and helpers for the N-way cache: FSM state encoding, default geometry widths,
// and the byte-enable to line-mask expansion used by the write merge.
package cache_pkg;

    localparam int S_OFFSET_DEF = 5;
    localparam int S_INDEX_DEF  = 3;
    localparam int LINE         = 8 * (2 ** S_OFFSET_DEF);
    localparam int TAG_W        = 32 - S_OFFSET_DEF - S_INDEX_DEF;
    localparam int WORD_SEL_W   = S_OFFSET_DEF - 2;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        FILL
    } state_t;

    // Place the 4 word byte lanes at the selected word of a line-wide byte mask.
    function automatic logic [LINE/8-1:0] be_to_line_mask(input logic [3:0] be,
                                                          input logic [WORD_SEL_W-1:0] word);
        be_to_line_mask = '0;
        be_to_line_mask[{word, 2'b00} +: 4] = be;
    endfunction

endpackage

// File: rtl/cache_repl.sv
// Per-set replacement state and victim choice. CACHE_PLRU_EN selects tree pseudo-LRU;
// otherwise a per-set round-robin counter that advances only on fills.
module cache_repl
    import cache_pkg::*;
#(
    parameter int S_INDEX  = 3,
    parameter int NUM_WAYS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [S_INDEX-1:0]          idx,
    input  logic                        upd,
    input  logic                        upd_fill,
    input  logic [$clog2(NUM_WAYS)-1:0] upd_way,
    output logic [$clog2(NUM_WAYS)-1:0] victim
);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int SETS  = 1 << S_INDEX;

`ifdef CACHE_PLRU_EN
    // Heap-ordered tree: node n (1-based) lives in bit n-1; a 0 bit points to the lower half.
    logic [NUM_WAYS-2:0] tree [SETS];
    logic [NUM_WAYS-2:0] tree_cur;
    logic [NUM_WAYS-2:0] tree_nxt;
    logic [NUM_WAYS-1:0] on_path;
    logic                unused_fill;

    assign unused_fill = upd_fill;
    assign tree_cur    = tree[idx];

    always_comb begin
        on_path = '1;
        for (int w = 0; w < NUM_WAYS; w++)
            for (int l = 0; l < WAY_W; l++)
                if (tree_cur[(1 << l) + (w >> (WAY_W - l)) - 1] != 1'(w >> (WAY_W - 1 - l)))
                    on_path[w] = 1'b0;
        victim = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--)
            if (on_path[w]) victim = WAY_W'(w);
    end

    always_comb begin
        tree_nxt = tree_cur;
        for (int w = 0; w < NUM_WAYS; w++)
            if (upd_way == WAY_W'(w))
                for (int l = 0; l < WAY_W; l++)
                    tree_nxt[(1 << l) + (w >> (WAY_W - l)) - 1] = ~1'(w >> (WAY_W - 1 - l));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) tree[s] <= '0;
        end else if (upd) begin
            tree[idx] <= tree_nxt;
        end
    end
`else
    logic [WAY_W-1:0] rr [SETS];
    logic [WAY_W-1:0] unused_way;

    assign unused_way = upd_way;
    assign victim     = rr[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) rr[s] <= '0;
        end else if (upd && upd_fill) begin
            rr[idx] <= rr[idx] + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back, write-allocate cache between a 32-bit CPU port and a
// line-wide memory port. Define CACHE_PLRU_EN for tree pseudo-LRU, else round-robin.
module cache_nway
    import cache_pkg::*;
#(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int NUM_WAYS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                mem_address,
    output logic [31:0]                mem_rdata,
    input  logic [31:0]                mem_wdata,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [3:0]                 mem_byte_enable,
    output logic                       mem_resp,
    input  logic [(8<<S_OFFSET)-1:0]   pmem_rdata,
    output logic [(8<<S_OFFSET)-1:0]   pmem_wdata,
    output logic [31:0]                pmem_address,
    output logic                       pmem_read,
    output logic                       pmem_write,
    input  logic                       pmem_resp
);
    localparam int LW    = 8 << S_OFFSET;
    localparam int TW    = 32 - S_OFFSET - S_INDEX;
    localparam int WW    = S_OFFSET - 2;
    localparam int SETS  = 1 << S_INDEX;
    localparam int WAY_W = $clog2(NUM_WAYS);

    state_t state, state_nxt;

    logic [TW-1:0]       tag_q;
    logic [S_INDEX-1:0]  idx_q;
    logic [WW-1:0]       word_q;
    logic                wr_q;
    logic [WAY_W-1:0]    victim_q;
    logic [31:0]         rdata_q;
    logic [1:0]          unused_addr_lsb;

    logic [LW-1:0]       data_arr  [NUM_WAYS][SETS];
    logic [TW-1:0]       tag_arr   [NUM_WAYS][SETS];
    logic [NUM_WAYS-1:0] valid_arr [SETS];
    logic [NUM_WAYS-1:0] dirty_arr [SETS];

    logic [NUM_WAYS-1:0] hit_vec;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    miss_way;
    logic [WAY_W-1:0]    repl_victim;
    logic [WAY_W-1:0]    repl_way;
    logic                repl_upd;
    logic                repl_fill;
    logic [LW-1:0]       hit_line;
    logic [31:0]         hit_word;
    logic [LW-1:0]       wr_line;
    logic [LW-1:0]       merged_line;
    logic [LW/8-1:0]     byte_mask;

    assign unused_addr_lsb = mem_address[1:0];

    // Scan high to low so the lowest-index matching way wins.
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            hit_vec[w] = valid_arr[idx_q][w] && (tag_arr[w][idx_q] == tag_q);
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
        hit = |hit_vec;
    end

    always_comb begin
        miss_way = repl_victim;
        for (int w = NUM_WAYS - 1; w >= 0; w--)
            if (!valid_arr[idx_q][w]) miss_way = WAY_W'(w);
    end

    assign hit_line = data_arr[hit_way][idx_q];
    assign hit_word = hit_line[{word_q, 5'b00000} +: 32];

    always_comb begin
        byte_mask   = be_to_line_mask(mem_byte_enable, word_q);
        wr_line     = {(LW/32){mem_wdata}};
        merged_line = hit_line;
        for (int b = 0; b < LW/8; b++)
            if (byte_mask[b]) merged_line[8*b +: 8] = wr_line[8*b +: 8];
    end

    always_comb begin
        state_nxt    = state;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        repl_upd     = 1'b0;
        repl_fill    = 1'b0;
        repl_way     = hit_way;
        case (state)
            IDLE: if (mem_read || mem_write) state_nxt = COMPARE;
            COMPARE: begin
                if (hit) begin
                    mem_resp  = 1'b1;
                    repl_upd  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = dirty_arr[idx_q][miss_way] ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_arr[victim_q][idx_q], idx_q, {S_OFFSET{1'b0}}};
                if (pmem_resp) state_nxt = FILL;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {tag_q, idx_q, {S_OFFSET{1'b0}}};
                if (pmem_resp) begin
                    state_nxt = COMPARE;
                    repl_upd  = 1'b1;
                    repl_fill = 1'b1;
                    repl_way  = victim_q;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The response cycle shows the live word; the register keeps it until the next response.
    assign mem_rdata  = mem_resp ? hit_word : rdata_q;
    assign pmem_wdata = data_arr[victim_q][idx_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tag_q    <= '0;
            idx_q    <= '0;
            word_q   <= '0;
            wr_q     <= 1'b0;
            victim_q <= '0;
            rdata_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                tag_q  <= mem_address[31 -: TW];
                idx_q  <= mem_address[S_OFFSET +: S_INDEX];
                word_q <= mem_address[2 +: WW];
                wr_q   <= mem_write;
            end
            if (state == COMPARE) begin
                if (hit) begin
                    rdata_q <= hit_word;
                    if (wr_q) dirty_arr[idx_q][hit_way] <= 1'b1;
                end else begin
                    victim_q <= miss_way;
                end
            end
            if (state == FILL && pmem_resp) begin
                valid_arr[idx_q][victim_q] <= 1'b1;
                dirty_arr[idx_q][victim_q] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == COMPARE && hit && wr_q) begin
            data_arr[hit_way][idx_q] <= merged_line;
        end else if (state == FILL && pmem_resp) begin
            data_arr[victim_q][idx_q] <= pmem_rdata;
            tag_arr[victim_q][idx_q]  <= tag_q;
        end
    end

    cache_repl #(
        .S_INDEX  (S_INDEX),
        .NUM_WAYS (NUM_WAYS)
    ) u_repl (
        .clk      (clk),
        .rst      (rst),
        .idx      (idx_q),
        .upd      (repl_upd),
        .upd_fill (repl_fill),
        .upd_way  (repl_way),
        .victim   (repl_victim)
    );

endmodule
